// File: rtl/restoring_divider.sv
// Sequential signed divider: 32-bit dividend / 16-bit divisor -> 16-bit
// quotient (truncated toward zero) and 16-bit remainder (sign of dividend).
// Radix-2 restoring iteration on magnitudes, one quotient bit per cycle,
// with a start/done pulse handshake matching the Karatsuba multiplier.
module restoring_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        done,
    output logic        div_by_zero,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Working registers for the operation in flight
    logic [31:0] r_wq;        // shifts out dividend bits, shifts in quotient bits
    logic [15:0] r_dvs;       // divisor magnitude (0x8000 represents 32768)
    logic [16:0] r_prem;      // partial remainder
    logic [5:0]  r_cnt;       // iteration counter
    logic        r_qsign;
    logic        r_rsign;
    logic [15:0] r_dvd_lo;    // raw dividend low half, reported on divide by zero

    // Magnitudes: the two's-complement negate read as unsigned is exact even
    // for -2^31 and -32768, so no extra sign bit needs to be carried.
    logic [31:0] w_dvd_mag;
    logic [15:0] w_dvs_mag;

    // One restoring step
    logic [16:0] w_shift;
    logic [17:0] w_trial;

    // Result shaping
    logic        w_ovf;
    logic        w_dz;

    // Operand magnitudes for the accepting edge
    always_comb begin
        w_dvd_mag = dividend[31] ? (32'd0 - dividend) : dividend;
        w_dvs_mag = divisor[15]  ? (16'd0 - divisor)  : divisor;
    end

    // Shift the next dividend bit into the partial remainder and trial-subtract
    always_comb begin
        w_shift = {r_prem[15:0], r_wq[31]};
        w_trial = {1'b0, w_shift} - {2'b00, r_dvs};
    end

    // Exception classification of the finished operation
    always_comb begin
        w_dz  = (r_dvs == 16'd0);
        w_ovf = r_qsign ? (r_wq > 32'd32768) : (r_wq > 32'd32767);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (divisor == 16'd0) ? FINISH : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == 6'd31) begin
                    w_next = FINISH;
                end
            end
            FINISH: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture in IDLE and one restoring iteration per BUSY cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wq     <= '0;
            r_dvs    <= '0;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_qsign  <= 1'b0;
            r_rsign  <= 1'b0;
            r_dvd_lo <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_wq     <= w_dvd_mag;
                        r_dvs    <= w_dvs_mag;
                        r_prem   <= '0;
                        r_cnt    <= '0;
                        r_qsign  <= dividend[31] ^ divisor[15];
                        r_rsign  <= dividend[31];
                        r_dvd_lo <= dividend[15:0];
                    end
                end
                BUSY: begin
                    if (w_trial[17]) begin
                        // Negative trial: restore (keep the shifted value), bit 0
                        r_prem <= w_shift;
                        r_wq   <= {r_wq[30:0], 1'b0};
                    end else begin
                        r_prem <= w_trial[16:0];
                        r_wq   <= {r_wq[30:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 6'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers and the one-cycle done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quotient    <= '0;
            remainder   <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            done <= (r_state == FINISH);
            if (r_state == FINISH) begin
                if (w_dz) begin
                    div_by_zero <= 1'b1;
                    overflow    <= 1'b0;
                    quotient    <= '1;
                    remainder   <= r_dvd_lo;
                end else if (w_ovf) begin
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b1;
                    quotient    <= r_qsign ? 16'h8000 : 16'h7FFF;
                    remainder   <= '0;
                end else begin
                    div_by_zero <= 1'b0;
                    overflow    <= 1'b0;
                    quotient    <= r_qsign ? (16'd0 - r_wq[15:0]) : r_wq[15:0];
                    remainder   <= r_rsign ? 16'(17'd0 - r_prem) : r_prem[15:0];
                end
            end
        end
    end

endmodule
